// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: owns the fetch PC, reads the instruction ROM, and hands words to decode through a 2-entry FIFO.
// Optional macro IFETCH_MISALIGN_EN adds the fetch_fault port and a sticky FAULT state for misaligned redirects.
module ifetch_unit #(
   parameter int          MEMORY_TYPE = 0,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_re,
   output logic [10:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
`ifdef IFETCH_MISALIGN_EN
   ,
   output logic        fetch_fault
`endif
);

`ifdef IFETCH_MISALIGN_EN
   typedef enum logic {RUN, FAULT} state_t;
`else
   typedef enum logic {RUN} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] fetchPc_q, fetchPc_d;
   logic [31:0] fifoInstr_q [2];
   logic [31:0] fifoPc_q [2];
   logic        rdPtr_q, rdPtr_d;
   logic        wrPtr_q, wrPtr_d;
   logic [1:0]  count_q, count_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflightPc_q, inflightPc_d;
   logic        fault_q, fault_d;

   logic        running;
   logic        pop;
   logic        issue;
   logic        push;
   logic        misaligned;
   logic [1:0]  occupancy;
   logic [31:0] pushInstr;
   logic [31:0] pushPc;

   // Combinational handshake, issue and capture decisions plus next-state values.
   always_comb begin
      running    = (state_q == RUN) && !rst;
      instr_valid = running && (count_q != 2'd0);
      pop        = instr_valid && instr_ready;
      occupancy  = count_q + {1'b0, inflight_q} - {1'b0, pop};
      issue      = running && !redirect && (occupancy < 2'd2);
      imem_re    = issue;
      imem_addr  = rst ? RESET_PC[12:2] : fetchPc_q[12:2];
      instr      = instr_valid ? fifoInstr_q[rdPtr_q] : 32'h0;
      instr_pc   = instr_valid ? fifoPc_q[rdPtr_q]    : 32'h0;
`ifdef IFETCH_MISALIGN_EN
      misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif

      if (MEMORY_TYPE == 0) begin
         push   = issue;
         pushPc = fetchPc_q;
      end else begin
         // A response still outstanding when redirect arrives is dropped here.
         push   = running && inflight_q && !redirect;
         pushPc = inflightPc_q;
      end
      pushInstr = imem_data;

      state_d      = state_q;
      fetchPc_d    = fetchPc_q;
      rdPtr_d      = rdPtr_q;
      wrPtr_d      = wrPtr_q;
      count_d      = count_q;
      inflight_d   = (MEMORY_TYPE != 0) && issue;
      inflightPc_d = inflightPc_q;
      fault_d      = fault_q;

      if (issue) begin
         fetchPc_d    = fetchPc_q + 32'd4;
         inflightPc_d = fetchPc_q;
      end

      if (redirect) begin
         fetchPc_d = redirect_pc & ~32'h3;
         rdPtr_d   = 1'b0;
         wrPtr_d   = 1'b0;
         count_d   = 2'd0;
      end else begin
         if (push) wrPtr_d = ~wrPtr_q;
         if (pop)  rdPtr_d = ~rdPtr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end

`ifdef IFETCH_MISALIGN_EN
      if (misaligned) begin
         state_d = FAULT;
         fault_d = 1'b1;
      end
`endif
   end

`ifdef IFETCH_MISALIGN_EN
   assign fetch_fault = fault_q;
`endif

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         fetchPc_q    <= RESET_PC;
         rdPtr_q      <= 1'b0;
         wrPtr_q      <= 1'b0;
         count_q      <= 2'd0;
         inflight_q   <= 1'b0;
         inflightPc_q <= 32'h0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetchPc_q    <= fetchPc_d;
         rdPtr_q      <= rdPtr_d;
         wrPtr_q      <= wrPtr_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         inflightPc_q <= inflightPc_d;
         fault_q      <= fault_d;
      end
   end

   // FIFO storage needs no reset; entries are only visible through instr_valid.
   always_ff @(posedge clk) begin
      if (!rst && push && !redirect && !misaligned) begin
         fifoInstr_q[wrPtr_q] <= pushInstr;
         fifoPc_q[wrPtr_q]    <= pushPc;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: runs a combinational-ROM instance and a BSRAM-ROM instance side by side on shared stimulus.
// Compile with IFETCH_MISALIGN_EN to exercise the fault path instead of redirect masking.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic        redir;
   logic [31:0] rpc;

   logic        re0, re1;
   logic [10:0] addr0, addr1;
   logic [31:0] data0, data1;
   logic        valid0, valid1;
   logic [31:0] instr0, instr1;
   logic [31:0] ipc0, ipc1;
`ifdef IFETCH_MISALIGN_EN
   logic        fault0, fault1;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ifetch_unit #(.MEMORY_TYPE(0), .RESET_PC(32'h0)) dut0 (
      .clk(clk), .rst(rst), .imem_re(re0), .imem_addr(addr0), .imem_data(data0),
      .instr_valid(valid0), .instr_ready(ready), .instr(instr0), .instr_pc(ipc0),
      .redirect(redir), .redirect_pc(rpc)
`ifdef IFETCH_MISALIGN_EN
      , .fetch_fault(fault0)
`endif
   );

   ifetch_unit #(.MEMORY_TYPE(1), .RESET_PC(32'h0)) dut1 (
      .clk(clk), .rst(rst), .imem_re(re1), .imem_addr(addr1), .imem_data(data1),
      .instr_valid(valid1), .instr_ready(ready), .instr(instr1), .instr_pc(ipc1),
      .redirect(redir), .redirect_pc(rpc)
`ifdef IFETCH_MISALIGN_EN
      , .fetch_fault(fault1)
`endif
   );

   // ROM contents: word n holds 0x100 + n.
   function automatic logic [31:0] romWord(input logic [31:0] pc);
      return 32'h100 + {21'b0, pc[12:2]};
   endfunction

   assign data0 = 32'h100 + {21'b0, addr0};

   always @(posedge clk) begin
      if (re1) data1 <= 32'h100 + {21'b0, addr1};
   end

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        v0;
      logic [31:0] pc0;
      logic        re0;
      logic        v1;
      logic [31:0] pc1;
      logic        re1;
      logic        addrChk;
      logic [10:0] addrExp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic rdr, input logic [31:0] rp,
                               input logic ev0, input logic [31:0] epc0, input logic ere0,
                               input logic ev1, input logic [31:0] epc1, input logic ere1,
                               input logic ac, input logic [10:0] ae);
      vec_t v;
      v.ready = rd; v.redir = rdr; v.rpc = rp;
      v.v0 = ev0; v.pc0 = epc0; v.re0 = ere0;
      v.v1 = ev1; v.pc1 = epc1; v.re1 = ere1;
      v.addrChk = ac; v.addrExp = ae;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic rd, input logic rdr, input logic [31:0] rp);
      @(negedge clk);
      rst   = r;
      ready = rd;
      redir = rdr;
      rpc   = rp;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      checkOutput($sformatf("c%0d valid0", idx), {31'b0, valid0}, {31'b0, v.v0});
      checkOutput($sformatf("c%0d re0", idx),    {31'b0, re0},    {31'b0, v.re0});
      checkOutput($sformatf("c%0d valid1", idx), {31'b0, valid1}, {31'b0, v.v1});
      checkOutput($sformatf("c%0d re1", idx),    {31'b0, re1},    {31'b0, v.re1});
      if (v.v0) begin
         checkOutput($sformatf("c%0d pc0", idx),    ipc0,   v.pc0);
         checkOutput($sformatf("c%0d instr0", idx), instr0, romWord(v.pc0));
      end
      if (v.v1) begin
         checkOutput($sformatf("c%0d pc1", idx),    ipc1,   v.pc1);
         checkOutput($sformatf("c%0d instr1", idx), instr1, romWord(v.pc1));
      end
      if (v.addrChk) begin
         checkOutput($sformatf("c%0d addr0", idx), {21'b0, addr0}, {21'b0, v.addrExp});
         checkOutput($sformatf("c%0d addr1", idx), {21'b0, addr1}, {21'b0, v.addrExp});
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; ready = 1'b0; redir = 1'b0; rpc = 32'h0;

      // Streaming, backpressure, redirect with kill, and PC wrap; cycle 0 is the first cycle after reset.
      vecs.push_back(mk(1, 0, 0, 0, 0,           1, 0, 0,           1, 1, 11'h000));
      vecs.push_back(mk(1, 0, 0, 1, 32'h0,       1, 0, 0,           1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h4,       1, 1, 32'h0,       1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h8,       1, 1, 32'h4,       1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hC,       1, 1, 32'h8,       0, 0, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, 0, 1, 32'hC,    0, 1, 32'h8,       0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'hC,       1, 1, 32'h8,       1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h10,      1, 1, 32'hC,       1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h14,      1, 1, 32'h10,      1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h18,      1, 1, 32'h14,      1, 0, 0));
      vecs.push_back(mk(1, 1, 32'h40, 1, 32'h1C, 0, 1, 32'h18,      0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0,           1, 0, 0,           1, 1, 11'h010));
      vecs.push_back(mk(1, 0, 0, 1, 32'h40,      1, 0, 0,           1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h44,      1, 1, 32'h40,      1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h48,      1, 1, 32'h44,      1, 0, 0));
      vecs.push_back(mk(1, 1, 32'hFFFF_FFFC, 1, 32'h4C, 0, 1, 32'h48, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0,           1, 0, 0,           1, 1, 11'h7FF));
      vecs.push_back(mk(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0,         1, 1, 11'h000));
      vecs.push_back(mk(1, 0, 0, 1, 32'h0,       1, 1, 32'hFFFF_FFFC, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h4,       1, 1, 32'h0,       1, 0, 0));

      // Outputs while reset is held.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("rst re0",    {31'b0, re0},    32'h0);
      checkOutput("rst re1",    {31'b0, re1},    32'h0);
      checkOutput("rst valid0", {31'b0, valid0}, 32'h0);
      checkOutput("rst valid1", {31'b0, valid1}, 32'h0);
      checkOutput("rst instr0", instr0,          32'h0);
      checkOutput("rst ipc1",   ipc1,            32'h0);
      checkOutput("rst addr0",  {21'b0, addr0},  32'h0);

      foreach (vecs[i]) begin
         applyStimulus(0, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
         checkVector(i, vecs[i]);
      end

`ifdef IFETCH_MISALIGN_EN
      // Misaligned redirect latches a sticky fault and stops fetching.
      applyStimulus(0, 1, 1, 32'h42);
      checkOutput("mis re0", {31'b0, re0}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 0);
         checkOutput($sformatf("fault0 k%0d", k), {31'b0, fault0}, 32'h1);
         checkOutput($sformatf("fault1 k%0d", k), {31'b0, fault1}, 32'h1);
         checkOutput($sformatf("fault re0 k%0d", k), {31'b0, re0}, 32'h0);
         checkOutput($sformatf("fault re1 k%0d", k), {31'b0, re1}, 32'h0);
         checkOutput($sformatf("fault valid0 k%0d", k), {31'b0, valid0}, 32'h0);
         checkOutput($sformatf("fault valid1 k%0d", k), {31'b0, valid1}, 32'h0);
      end
`else
      // Low redirect bits are masked: 0x82 fetches from 0x80.
      applyStimulus(0, 1, 1, 32'h82);
      checkOutput("mask re0", {31'b0, re0}, 32'h0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("mask addr0", {21'b0, addr0}, 32'h20);
      checkOutput("mask addr1", {21'b0, addr1}, 32'h20);
      applyStimulus(0, 1, 0, 0);
      checkOutput("mask valid0", {31'b0, valid0}, 32'h1);
      checkOutput("mask pc0",    ipc0,            32'h80);
      checkOutput("mask instr0", instr0,          romWord(32'h80));
      applyStimulus(0, 1, 0, 0);
      checkOutput("mask valid1", {31'b0, valid1}, 32'h1);
      checkOutput("mask pc1",    ipc1,            32'h80);
`endif

      // Reset wins over a simultaneous redirect, then fetch restarts at RESET_PC.
      applyStimulus(1, 1, 1, 32'h100);
      checkOutput("rr re0",    {31'b0, re0},    32'h0);
      checkOutput("rr re1",    {31'b0, re1},    32'h0);
      checkOutput("rr valid0", {31'b0, valid0}, 32'h0);
      checkOutput("rr addr1",  {21'b0, addr1},  32'h0);
      applyStimulus(0, 1, 0, 0);
`ifdef IFETCH_MISALIGN_EN
      checkOutput("rr fault0", {31'b0, fault0}, 32'h0);
`endif
      checkOutput("rr c0 valid0", {31'b0, valid0}, 32'h0);
      checkOutput("rr c0 re0",    {31'b0, re0},    32'h1);
      checkOutput("rr c0 addr0",  {21'b0, addr0},  32'h0);
      checkOutput("rr c0 ipc0",   ipc0,            32'h0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("rr c1 valid0", {31'b0, valid0}, 32'h1);
      checkOutput("rr c1 pc0",    ipc0,            32'h0);
      checkOutput("rr c1 instr0", instr0,          32'h100);
      checkOutput("rr c1 valid1", {31'b0, valid1}, 32'h0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("rr c2 valid1", {31'b0, valid1}, 32'h1);
      checkOutput("rr c2 pc1",    ipc1,            32'h0);
      checkOutput("rr c2 pc0",    ipc0,            32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
